// File: rtl/lsu_hs_pkg.sv
// lsu_hs_pkg: shared types for the load/store unit and its store buffer.
package lsu_hs_pkg;
    localparam int SB_ADDR_W = 32;
    typedef enum logic [2:0] {
        FMT_B  = 3'b000,
        FMT_H  = 3'b001,
        FMT_W  = 3'b010,
        FMT_BU = 3'b100,
        FMT_HU = 3'b101
    } mem_fmt_t;
    typedef enum logic [1:0] {IDLE, LD_REQ, LD_WAIT} lsu_state_t;
    typedef struct packed {
        logic [SB_ADDR_W-3:0] waddr;
        logic [31:0]          data;
        logic [3:0]           strb;
    } sb_entry_t;
endpackage

// File: rtl/lsu_hs_store_buf.sv
// store_buf: synchronous FIFO of posted stores; push and pop may coincide even when full.
module store_buf
    import lsu_hs_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  logic      pop,
    input  sb_entry_t din,
    output sb_entry_t head,
    output logic      full,
    output logic      empty
);
    localparam int PW = $clog2(DEPTH);
    sb_entry_t mem [DEPTH];
    logic [PW-1:0] wr, rd;
    logic [PW:0] cnt;
    always_ff @(posedge clk) begin
        if (rst) begin
            wr  <= '0;
            rd  <= '0;
            cnt <= '0;
        end else begin
            if (push) wr <= wr + 1'b1;
            if (pop) rd <= rd + 1'b1;
            cnt <= cnt + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem[wr] <= din;
    end
    assign head  = mem[rd];
    assign full  = cnt == (PW+1)'(DEPTH);
    assign empty = cnt == '0;
endmodule

// File: rtl/lsu_hs.sv
// lsu_hs: load/store unit with ready/valid bus handshake, posted store buffer,
// misalignment detection and load timeout.
module lsu_hs
    import lsu_hs_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int SB_DEPTH    = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [2:0]        req_fmt,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              stall,
    output logic              rsp_valid,
    output logic [31:0]       rdata,
    output logic              misalign,
    output logic              timeout_err,
    output logic              sb_empty,
    output logic              bus_valid,
    input  logic              bus_ready,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_wstrb,
    output logic [31:0]       bus_wdata,
    input  logic              bus_rvalid,
    input  logic [31:0]       bus_rdata
);
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    lsu_state_t state;
    logic [ADDR_W-1:0] ld_addr;
    logic [2:0] ld_fmt;
    logic [CW-1:0] cnt;
    logic is_b, is_h, ld, st, full, push, pop, rsp_ok, to;
    sb_entry_t din, head;
    logic [31:0] sh, ext;
    assign is_b     = req_fmt == FMT_B || req_fmt == FMT_BU;
    assign is_h     = req_fmt == FMT_H || req_fmt == FMT_HU;
    assign misalign = req_valid && (is_h ? req_addr[0] : !is_b && req_addr[1:0] != 2'b00);
    assign st       = req_valid && !misalign && req_we;
    assign ld       = req_valid && !misalign && !req_we;
    assign pop      = state == IDLE && !sb_empty && bus_ready;
    assign push     = st && (!full || pop);
    assign rsp_ok   = state == LD_WAIT && bus_rvalid;
    assign to       = state == LD_WAIT && !bus_rvalid && cnt == CW'(TIMEOUT_CYC - 1);
    assign rsp_valid   = rsp_ok || to;
    assign timeout_err = to;
    assign stall    = st ? full && !pop : ld && !rsp_valid;
    assign din = '{
        waddr: req_addr[ADDR_W-1:2],
        data:  is_b ? {4{req_wdata[7:0]}} : is_h ? {2{req_wdata[15:0]}} : req_wdata,
        strb:  is_b ? 4'b0001 << req_addr[1:0] : is_h ? (req_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111
    };
    store_buf #(.DEPTH(SB_DEPTH)) u_sb (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .din(din),
        .head(head), .full(full), .empty(sb_empty)
    );
    // IDLE owns the bus for store drain; LD_REQ presents the latched load.
    assign bus_valid = state == LD_REQ || (state == IDLE && !sb_empty);
    assign bus_we    = state == IDLE;
    assign bus_addr  = state == IDLE ? {head.waddr, 2'b00} : {ld_addr[ADDR_W-1:2], 2'b00};
    assign bus_wstrb = state == IDLE ? head.strb : 4'b0000;
    assign bus_wdata = state == IDLE ? head.data : 32'h0;
    assign sh  = bus_rdata >> {ld_addr[1:0], 3'b000};
    assign ext = ld_fmt == FMT_B  ? {{24{sh[7]}}, sh[7:0]} :
                 ld_fmt == FMT_BU ? {24'h0, sh[7:0]} :
                 ld_fmt == FMT_H  ? {{16{sh[15]}}, sh[15:0]} :
                 ld_fmt == FMT_HU ? {16'h0, sh[15:0]} : sh;
    assign rdata = rsp_ok ? ext : 32'h0;
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            ld_addr <= '0;
            ld_fmt  <= '0;
        end else begin
            case (state)
                IDLE: if (ld && sb_empty) begin
                    state   <= LD_REQ;
                    ld_addr <= req_addr;
                    ld_fmt  <= req_fmt;
                end
                LD_REQ: if (bus_ready) begin
                    state <= LD_WAIT;
                    cnt   <= '0;
                end
                LD_WAIT: begin
                    cnt <= cnt + 1'b1;
                    if (rsp_valid) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_hs.sv
// tb_lsu_hs: directed self-checking bench for lsu_hs (TIMEOUT_CYC=8).
module tb_lsu_hs;
    logic clk, rst, req_valid, req_we, stall, rsp_valid, misalign, timeout_err, sb_empty;
    logic bus_valid, bus_ready, bus_we, bus_rvalid;
    logic [2:0] req_fmt;
    logic [31:0] req_addr, req_wdata, rdata, bus_addr, bus_wdata, bus_rdata;
    logic [3:0] bus_wstrb;
    int checks = 0, failures = 0;

    lsu_hs #(.ADDR_W(32), .SB_DEPTH(4), .TIMEOUT_CYC(8)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .req_fmt(req_fmt),
        .req_addr(req_addr), .req_wdata(req_wdata), .stall(stall), .rsp_valid(rsp_valid),
        .rdata(rdata), .misalign(misalign), .timeout_err(timeout_err), .sb_empty(sb_empty),
        .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    task automatic drive(input logic v, input logic we, input logic [2:0] fmt,
                         input logic [31:0] addr, input logic [31:0] wd);
        req_valid = v; req_we = we; req_fmt = fmt; req_addr = addr; req_wdata = wd;
    endtask

    task automatic test_reset;
        rst = 1; bus_ready = 0; bus_rvalid = 0; bus_rdata = 0;
        drive(0, 0, 3'b010, 0, 0);
        repeat (2) @(negedge clk);
        rst = 0; #1;
        checks++;
        if ({bus_valid, rsp_valid, timeout_err, stall, sb_empty} !== 5'b00001) begin
            failures++; $display("FAIL reset_flags got=%b exp=00001", {bus_valid, rsp_valid, timeout_err, stall, sb_empty});
        end
        checks++;
        if (rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
    endtask

    task automatic test_store_word;
        @(negedge clk); bus_ready = 1; drive(1, 1, 3'b010, 32'h100, 32'hDEADBEEF); #1;
        checks++;
        if (stall !== 1'b0) begin failures++; $display("FAIL sw_stall got=%b exp=0", stall); end
        @(negedge clk); drive(0, 0, 3'b010, 0, 0); #1;
        checks++;
        if ({bus_valid, bus_we, bus_addr, bus_wstrb, bus_wdata} !== {1'b1, 1'b1, 32'h100, 4'b1111, 32'hDEADBEEF}) begin
            failures++; $display("FAIL sw_bus got=%b%b %h %b %h exp=11 00000100 1111 deadbeef",
                                 bus_valid, bus_we, bus_addr, bus_wstrb, bus_wdata);
        end
        @(negedge clk); #1;
        checks++;
        if (sb_empty !== 1'b1) begin failures++; $display("FAIL sw_drained got=%b exp=1", sb_empty); end
    endtask

    task automatic test_byte;
        logic [31:0] exp;
        @(negedge clk); drive(1, 1, 3'b000, 32'h103, 32'h000000AB);
        @(negedge clk); drive(0, 0, 3'b010, 0, 0); #1;
        checks++;
        if ({bus_addr, bus_wstrb, bus_wdata} !== {32'h100, 4'b1000, 32'hABABABAB}) begin
            failures++; $display("FAIL sb_lanes got=%h %b %h exp=00000100 1000 abababab", bus_addr, bus_wstrb, bus_wdata);
        end
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            exp = k == 0 ? 32'hFFFFFF80 : 32'h00000080;
            @(negedge clk); drive(1, 0, k == 0 ? 3'b000 : 3'b100, 32'h103, 0); #1;
            checks++;
            if (stall !== 1'b1) begin failures++; $display("FAIL lb%0d_stall got=%b exp=1", k, stall); end
            @(negedge clk); #1;
            checks++;
            if ({bus_valid, bus_we, bus_addr, stall} !== {1'b1, 1'b0, 32'h100, 1'b1}) begin
                failures++; $display("FAIL lb%0d_req got=%b%b %h %b exp=10 00000100 1", k, bus_valid, bus_we, bus_addr, stall);
            end
            @(negedge clk); bus_rvalid = 1; bus_rdata = 32'h80000000; #1;
            checks++;
            if ({rsp_valid, stall, rdata} !== {1'b1, 1'b0, exp}) begin
                failures++; $display("FAIL lb%0d_rsp got=%b%b %h exp=10 %h", k, rsp_valid, stall, rdata, exp);
            end
            @(negedge clk); bus_rvalid = 0; drive(0, 0, 3'b010, 0, 0);
        end
    endtask

    task automatic test_full;
        logic [31:0] exp_d [5] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 32'h55555555};
        @(negedge clk); bus_ready = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); drive(1, 1, 3'b010, 32'h300 + 32'(4 * i), exp_d[i]); #1;
            checks++;
            if (stall !== 1'b0) begin failures++; $display("FAIL fill%0d_stall got=%b exp=0", i, stall); end
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); drive(1, 1, 3'b010, 32'h310, exp_d[4]); #1;
            checks++;
            if ({stall, bus_valid, bus_we, bus_addr, bus_wdata, bus_wstrb} !== {3'b111, 32'h300, exp_d[0], 4'b1111}) begin
                failures++; $display("FAIL full%0d_hold got=%b%b%b %h %h %b exp=111 00000300 11111111 1111",
                                     i, stall, bus_valid, bus_we, bus_addr, bus_wdata, bus_wstrb);
            end
        end
        @(negedge clk); bus_ready = 1; #1;
        checks++;
        if ({stall, bus_addr} !== {1'b0, 32'h300}) begin
            failures++; $display("FAIL full_pushpop got=%b %h exp=0 00000300", stall, bus_addr);
        end
        for (int j = 1; j < 5; j++) begin
            @(negedge clk); drive(0, 0, 3'b010, 0, 0); #1;
            checks++;
            if ({bus_valid, bus_addr, bus_wdata} !== {1'b1, 32'h300 + 32'(4 * j), exp_d[j]}) begin
                failures++; $display("FAIL drain%0d got=%b %h %h exp=1 %h %h", j, bus_valid, bus_addr, bus_wdata,
                                     32'h300 + 32'(4 * j), exp_d[j]);
            end
        end
        @(negedge clk); #1;
        checks++;
        if (sb_empty !== 1'b1) begin failures++; $display("FAIL full_empty got=%b exp=1", sb_empty); end
    endtask

    task automatic test_back_to_back;
        @(negedge clk); bus_ready = 0; drive(1, 1, 3'b010, 32'h200, 32'hCAFEF00D); #1;
        checks++;
        if (stall !== 1'b0) begin failures++; $display("FAIL b2b_sw_stall got=%b exp=0", stall); end
        @(negedge clk); drive(1, 0, 3'b010, 32'h200, 0); #1;
        checks++;
        if ({stall, bus_valid, bus_we, bus_addr} !== {3'b111, 32'h200}) begin
            failures++; $display("FAIL b2b_wr_first got=%b%b%b %h exp=111 00000200", stall, bus_valid, bus_we, bus_addr);
        end
        @(negedge clk); bus_ready = 1; #1;
        checks++;
        if ({stall, bus_valid, bus_we} !== 3'b111) begin
            failures++; $display("FAIL b2b_wr_accept got=%b exp=111", {stall, bus_valid, bus_we});
        end
        @(negedge clk); #1;
        checks++;
        if ({stall, bus_valid} !== 2'b10) begin
            failures++; $display("FAIL b2b_gap got=%b exp=10", {stall, bus_valid});
        end
        @(negedge clk); #1;
        checks++;
        if ({stall, bus_valid, bus_we, bus_addr} !== {3'b110, 32'h200}) begin
            failures++; $display("FAIL b2b_rd got=%b%b%b %h exp=110 00000200", stall, bus_valid, bus_we, bus_addr);
        end
        @(negedge clk); bus_rvalid = 1; bus_rdata = 32'hCAFEF00D; #1;
        checks++;
        if ({rsp_valid, stall, rdata} !== {2'b10, 32'hCAFEF00D}) begin
            failures++; $display("FAIL b2b_rsp got=%b%b %h exp=10 cafef00d", rsp_valid, stall, rdata);
        end
        @(negedge clk); bus_rvalid = 0; drive(0, 0, 3'b010, 0, 0);
    endtask

    task automatic test_misalign;
        @(negedge clk); drive(1, 0, 3'b001, 32'h101, 0); #1;
        checks++;
        if ({misalign, stall, bus_valid} !== 3'b100) begin
            failures++; $display("FAIL mis_lh got=%b exp=100", {misalign, stall, bus_valid});
        end
        @(negedge clk); #1;
        checks++;
        if (bus_valid !== 1'b0) begin failures++; $display("FAIL mis_lh_nobus got=%b exp=0", bus_valid); end
        @(negedge clk); drive(1, 1, 3'b010, 32'h102, 32'h12345678); #1;
        checks++;
        if ({misalign, stall} !== 2'b10) begin
            failures++; $display("FAIL mis_sw got=%b exp=10", {misalign, stall});
        end
        @(negedge clk); drive(0, 0, 3'b010, 0, 0); #1;
        checks++;
        if ({sb_empty, bus_valid} !== 2'b10) begin
            failures++; $display("FAIL mis_sw_noq got=%b exp=10", {sb_empty, bus_valid});
        end
    endtask

    task automatic test_timeout;
        @(negedge clk); bus_ready = 1; bus_rvalid = 0; bus_rdata = 32'hFFFFFFFF; drive(1, 0, 3'b010, 32'h400, 0);
        @(negedge clk);
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk); #1;
            checks++;
            if (i < 8 && {rsp_valid, timeout_err, stall} !== 3'b001) begin
                failures++; $display("FAIL to_wait%0d got=%b exp=001", i, {rsp_valid, timeout_err, stall});
            end else if (i == 8 && {rsp_valid, timeout_err, stall, rdata} !== {3'b110, 32'h0}) begin
                failures++; $display("FAIL to_fire got=%b %h exp=110 00000000", {rsp_valid, timeout_err, stall}, rdata);
            end
        end
        @(negedge clk); drive(0, 0, 3'b010, 0, 0); bus_rvalid = 1; #1;
        checks++;
        if ({rsp_valid, timeout_err} !== 2'b00) begin
            failures++; $display("FAIL to_late_rvalid got=%b exp=00", {rsp_valid, timeout_err});
        end
        @(negedge clk); bus_rvalid = 0;
    endtask

    task automatic test_reset_flush;
        @(negedge clk); bus_ready = 0; drive(1, 1, 3'b010, 32'h500, 32'hA5A5A5A5);
        @(negedge clk); drive(1, 1, 3'b010, 32'h504, 32'h5A5A5A5A);
        @(negedge clk); drive(0, 0, 3'b010, 0, 0); #1;
        checks++;
        if ({sb_empty, bus_valid} !== 2'b01) begin
            failures++; $display("FAIL flush_queued got=%b exp=01", {sb_empty, bus_valid});
        end
        rst = 1;
        @(negedge clk); rst = 0; #1;
        checks++;
        if ({sb_empty, bus_valid} !== 2'b10) begin
            failures++; $display("FAIL flush_reset got=%b exp=10", {sb_empty, bus_valid});
        end
    endtask

    initial begin
        test_reset;
        test_store_word;
        test_byte;
        test_full;
        test_back_to_back;
        test_misalign;
        test_timeout;
        test_reset_flush;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/lsu_hs.md
Name: lsu_hs

Overview:
Load/store unit that replaces the single-cycle RAM interface used by the 5-stage RV32 core. It adds a ready/valid bus handshake with wait states and a posted store buffer of parametrised depth. It stalls the pipeline for loads and on a full buffer, and flags misaligned accesses and load timeouts. It sits between the MEM stage of the datapath and the system bus.

Parameters:
ADDR_W, 32, byte-address width.
SB_DEPTH, 4, store buffer entries; power of two, at least 2.
TIMEOUT_CYC, 255, cycles in LD_WAIT without bus_rvalid before a timeout is declared; at least 1.

Ports:
clk  in  1  clock; one clock domain.
rst  in  1  synchronous, active-high reset.
req_valid  in  1  MEM stage holds a load or store.
req_we  in  1  1 = store, 0 = load.
req_fmt  in  3  mem_fmt_t, encoded as RISC-V funct3 (B=000, H=001, W=010, BU=100, HU=101).
req_addr  in  ADDR_W  byte address.
req_wdata  in  32  store data, right-aligned.
stall  out  1  hold the pipeline this cycle.
rsp_valid  out  1  load data valid this cycle (one-cycle pulse).
rdata  out  32  extended load data.
misalign  out  1  current request is misaligned.
timeout_err  out  1  one-cycle pulse, coincident with a timed-out rsp_valid.
sb_empty  out  1  store buffer empty; used for fence.
bus_valid  out  1  bus request valid.
bus_ready  in  1  bus accepts the request.
bus_we  out  1  write request.
bus_addr  out  ADDR_W  word-aligned address (low 2 bits are 0).
bus_wstrb  out  4  byte strobes.
bus_wdata  out  32  lane-replicated store data.
bus_rvalid  in  1  read response valid.
bus_rdata  in  32  read response data.

Behaviour:
- Reset (synchronous, rst=1):
  - FSM goes to IDLE; buffer pointers and count clear, so queued stores are discarded; timeout counter clears.
  - Outputs: bus_valid=0, rsp_valid=0, timeout_err=0, stall=0, sb_empty=1, rdata=0.
- Misalignment: H with addr[0]=1, or W with addr[1:0]≠0.
  - misalign=1 combinationally, stall=0.
  - No enqueue and no bus activity.
- Unlisted fmt encodings behave as W.
- Store (aligned):
  - Enqueued in the same cycle; stall=0.
  - If the buffer is full, stall=1 until a slot frees. Push is allowed in the same cycle as a pop.
- Store lane generation:
  - B: wdata = byte replicated 4×, wstrb = 0001<<addr[1:0].
  - H: wdata = {h,h}, wstrb = 0011<<{addr[1],0}.
  - W: wstrb = 1111.
- Buffer drain: in IDLE with sb_empty=0, bus_valid=1 with the head entry (bus_we=1). Pop on bus_valid&&bus_ready. Writes are posted; no response.
- Handshake: while bus_valid=1 and bus_ready=0, bus_addr, bus_we, bus_wstrb and bus_wdata are held stable.
- FSM states: IDLE, LD_REQ, LD_WAIT.
  - IDLE with an aligned load pending: stall=1.
    - If sb_empty=0, remain in IDLE and drain. This orders stores before the load (RAW safe).
    - If sb_empty=1, go to LD_REQ and latch the address and fmt.
  - LD_REQ: bus_valid=1, bus_we=0, stall=1. On bus_ready, go to LD_WAIT and clear the counter.
  - LD_WAIT: stall=1 until bus_rvalid. In that cycle rsp_valid=1 and stall=0, both combinational; next state is IDLE.
    - rdata = bus_rdata >> (8·addr[1:0]), then sign- or zero-extended per fmt.
- Minimum load latency: 3 cycles of stall-window; rsp_valid arrives in the 3rd cycle with ready=1 and rvalid one cycle after accept.
- Timeout: the counter increments each cycle in LD_WAIT.
  - When it reaches TIMEOUT_CYC with no bus_rvalid: rsp_valid=1, rdata=0, timeout_err=1, go to IDLE.
  - A late bus_rvalid arriving in IDLE or LD_REQ is ignored.
- New stores are accepted during a load's stall only after that load completes. The pipeline is stalled, so the request is unchanged.
- Only one bus transaction is outstanding at a time.

Decomposition:
- typepkg: add lsu_state_t (IDLE, LD_REQ, LD_WAIT) and sb_entry_t (word address ADDR_W-2, data 32, strb 4). mem_fmt_t is reused.
- Sub-module store_buf: a synchronous FIFO of sb_entry_t with push, pop, full and empty, supporting simultaneous push and pop when full.
- Lane and extend logic stays in lsu_hs.

Test Plan:
1. SW addr 0x100, data 0xDEADBEEF, bus_ready=1 → stall=0; next cycle bus_valid=1, bus_we=1, bus_addr=0x100, wstrb=1111, wdata=0xDEADBEEF.
2. SB addr 0x103, data 0xAB → wstrb=1000, wdata=0xABABABAB. Then LB 0x103 with bus_rdata=0x80000000 → rdata=0xFFFFFF80; LBU → rdata=0x00000080.
3. With bus_ready=0, issue 4 SW (buffer fills), then a 5th SW → stall=1 and bus outputs stable. Raise ready → 5th store is pushed in the first pop cycle; stores reach the bus in order.
4. SW 0x200 then LW 0x200 back-to-back, with rvalid one cycle after accept → load stalls until the store is accepted; the read is issued after; bus order is write then read; rsp_valid=1 with the bus_rdata value.
5. LH addr 0x101 → misalign=1, stall=0, bus_valid stays 0. SW 0x102 → misalign=1, sb_empty stays 1.
6. TIMEOUT_CYC=8, LW with no rvalid → after 8 LD_WAIT cycles: rsp_valid=1, rdata=0, timeout_err=1, then IDLE. Separately, rst with 2 queued stores and ready=0 → bus_valid=0 and sb_empty=1 the next cycle.
